// File: rtl/bus_mem_responder_if.sv
// rtl/bus_mem_responder_if.sv - CPU-side request/response bus of the memory responder
// Purpose: groups the CPU request (Address, Din, Rden, Wren) and the
// responder's reply (Dout, Ready, Err) into one bundle.
// Ports (signals):
//   Address  master->slave  word address
//   Din      master->slave  write data
//   Rden     master->slave  read request
//   Wren     master->slave  write request
//   Dout     slave->master  registered read data
//   Ready    slave->master  one-cycle response strobe
//   Err      slave->master  error strobe, qualified by Ready
interface bus_mem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Din;
  logic              Rden;
  logic              Wren;
  logic [DATA_W-1:0] Dout;
  logic              Ready;
  logic              Err;

  modport master (
    output Address, Din, Rden, Wren,
    input  Dout, Ready, Err
  );

  modport slave (
    input  Address, Din, Rden, Wren,
    output Dout, Ready, Err
  );
endinterface

// File: rtl/bus_mem_responder.sv
// rtl/bus_mem_responder.sv - single-port word memory answering CPU reads/writes with wait states
// Purpose: samples a CPU request in IDLE, optionally stalls WAIT_STATES
// cycles, performs the access and pulses Ready (with Err for illegal
// requests) for exactly one cycle. Counts successful reads and writes.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   bus       slave side of bus_mem_responder_if
//   ld_count  saturating count of successful reads
//   st_count  saturating count of successful writes
module bus_mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_mem_responder_if.slave   bus,
  output logic [7:0]           ld_count,
  output logic [7:0]           st_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [2:0]        wcnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_din;
  logic              lat_rd;
  logic              lat_wr;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_new;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_din;
  logic              acc_rd;
  logic              acc_wr;
  logic              acc_err;
  logic              do_access;
  logic [IDX_W-1:0]  acc_idx;

  // With no wait states the access uses the live bus inputs at the sampling
  // edge; otherwise it uses the values captured when the request was taken.
  always_comb begin
    req_new  = (state == IDLE) && (bus.Rden || bus.Wren);
    acc_addr = (state == IDLE) ? bus.Address : lat_addr;
    acc_din  = (state == IDLE) ? bus.Din     : lat_din;
    acc_rd   = (state == IDLE) ? bus.Rden    : lat_rd;
    acc_wr   = (state == IDLE) ? bus.Wren    : lat_wr;
    // Full-width unsigned compare so out-of-range addresses never alias.
    acc_err  = (acc_rd && acc_wr) || (32'(acc_addr) >= 32'(DEPTH));
    acc_idx  = acc_addr[IDX_W-1:0];
    // Gated by reset so the unreset array cannot be written while in reset.
    do_access = reset &&
                ((req_new && (WAIT_STATES == 0)) || ((state == WAIT) && (wcnt == 3'd0)));
  end

  // Memory contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (do_access && acc_wr && !acc_err) begin
      mem[acc_idx] <= acc_din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wcnt      <= 3'd0;
      lat_addr  <= '0;
      lat_din   <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
      bus.Dout  <= '0;
      bus.Ready <= 1'b0;
      bus.Err   <= 1'b0;
      ld_count  <= 8'd0;
      st_count  <= 8'd0;
    end else begin
      bus.Ready <= 1'b0;
      bus.Err   <= 1'b0;

      case (state)
        IDLE: begin
          if (req_new) begin
            if (WAIT_STATES == 0) begin
              state     <= RESP;
              bus.Ready <= 1'b1;
              bus.Err   <= acc_err;
            end else begin
              lat_addr <= bus.Address;
              lat_din  <= bus.Din;
              lat_rd   <= bus.Rden;
              lat_wr   <= bus.Wren;
              wcnt     <= 3'(WAIT_STATES - 1);
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wcnt != 3'd0) begin
            wcnt <= wcnt - 3'd1;
          end else begin
            state     <= RESP;
            bus.Ready <= 1'b1;
            bus.Err   <= acc_err;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (do_access) begin
        if (acc_err) begin
          if (acc_rd) bus.Dout <= '0;
        end else if (acc_wr) begin
          if (st_count != 8'hFF) st_count <= st_count + 8'd1;
        end else begin
          bus.Dout <= mem[acc_idx];
          if (ld_count != 8'hFF) ld_count <= ld_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// tb/tb_bus_mem_responder.sv - randomized self-checking bench for bus_mem_responder
// Three responders (0, 3 and 2 wait states) share clock and reset; each
// transaction is predicted by a behavioural model of memory, Dout and counters.
module tb_bus_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [15:0] t_addr [3];
  logic [15:0] t_din  [3];
  logic        t_rd   [3];
  logic        t_wr   [3];

  wire  [15:0] o_dout  [3];
  wire         o_ready [3];
  wire         o_err   [3];
  wire  [7:0]  o_ld    [3];
  wire  [7:0]  o_st    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
    bus_mem_responder_if #(.DATA_W(16), .ADDR_W(16)) bus ();
    assign bus.Address = t_addr[g];
    assign bus.Din     = t_din[g];
    assign bus.Rden    = t_rd[g];
    assign bus.Wren    = t_wr[g];
    assign o_dout[g]   = bus.Dout;
    assign o_ready[g]  = bus.Ready;
    assign o_err[g]    = bus.Err;
    bus_mem_responder #(
      .DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT_STATES(WS)
    ) dut (
      .clk      (clk),
      .reset    (rst_n),
      .bus      (bus.slave),
      .ld_count (o_ld[g]),
      .st_count (o_st[g])
    );
  end

  int checks = 0;
  int fails  = 0;

  logic [15:0] m_mem  [3][4096];
  logic [15:0] m_dout [3];
  int          m_ld   [3];
  int          m_st   [3];
  logic [15:0] wq     [3][$];

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_dout[d] = 16'h0;
      m_ld[d]   = 0;
      m_st[d]   = 0;
    end
  endtask

  // Err must never be seen without Ready on any responder.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (o_err[d] === 1'b1 && o_ready[d] !== 1'b1) begin
          fails++;
          $display("FAIL err_without_ready dut%0d: err=%b ready=%b want ready=1", d, o_err[d], o_ready[d]);
        end
      end
    end
  end

  // Entered just after a negedge with the responder idle; returns likewise.
  task automatic xact(input int d, input bit rd, input bit wr,
                      input logic [15:0] addr, input logic [15:0] din,
                      input bit inject, input string tag);
    bit e_err;
    int n;
    bit seen;
    e_err = (rd && wr) || (addr >= 16'd4096);
    if (e_err) begin
      if (rd) m_dout[d] = 16'h0;
    end else if (wr) begin
      m_mem[d][addr[11:0]] = din;
      wq[d].push_back(addr);
      if (m_st[d] < 255) m_st[d]++;
    end else begin
      m_dout[d] = m_mem[d][addr[11:0]];
      if (m_ld[d] < 255) m_ld[d]++;
    end

    t_addr[d] = addr;
    t_din[d]  = din;
    t_rd[d]   = rd;
    t_wr[d]   = wr;
    n = 0;
    seen = 0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      if (o_ready[d] === 1'b1) seen = 1;
      else if (inject && n == 1) t_wr[d] = 1'b1;
      else if (inject && n == 2) t_wr[d] = 1'b0;
    end
    checks++;
    if (!seen || n != ws_of(d) + 1) begin
      fails++;
      $display("FAIL %s latency dut%0d: got %0d cycles (seen=%0b) want %0d", tag, d, n, seen, ws_of(d) + 1);
    end
    checks++;
    if (o_err[d] !== e_err) begin
      fails++;
      $display("FAIL %s err dut%0d: got %b want %b", tag, d, o_err[d], e_err);
    end
    checks++;
    if (o_dout[d] !== m_dout[d]) begin
      fails++;
      $display("FAIL %s dout dut%0d: got %h want %h", tag, d, o_dout[d], m_dout[d]);
    end
    checks++;
    if (o_ld[d] !== 8'(m_ld[d]) || o_st[d] !== 8'(m_st[d])) begin
      fails++;
      $display("FAIL %s counts dut%0d: got ld=%0d st=%0d want ld=%0d st=%0d", tag, d, o_ld[d], o_st[d], m_ld[d], m_st[d]);
    end
    t_rd[d] = 1'b0;
    t_wr[d] = 1'b0;
    @(negedge clk);
    checks++;
    if (o_ready[d] !== 1'b0 || o_err[d] !== 1'b0) begin
      fails++;
      $display("FAIL %s ready_one_cycle dut%0d: got ready=%b err=%b want 0 0", tag, d, o_ready[d], o_err[d]);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (o_ready[d] !== 1'b0 || o_err[d] !== 1'b0 || o_dout[d] !== 16'h0 ||
          o_ld[d] !== 8'h0 || o_st[d] !== 8'h0) begin
        fails++;
        $display("FAIL %s dut%0d: got ready=%b err=%b dout=%h ld=%0d st=%0d want all 0",
                 tag, d, o_ready[d], o_err[d], o_dout[d], o_ld[d], o_st[d]);
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      t_addr[d] = 16'h0; t_din[d] = 16'h0; t_rd[d] = 1'b0; t_wr[d] = 1'b0;
    end
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
  endtask

  task automatic test_basic_ws0();
    xact(0, 0, 1, 16'h0005, 16'h1234, 0, "ws0_write");
    xact(0, 1, 0, 16'h0005, 16'h0000, 0, "ws0_read");
  endtask

  task automatic test_wait_states();
    xact(1, 0, 1, 16'h0FFF, 16'hBEEF, 0, "ws3_write");
    xact(1, 1, 0, 16'h0FFF, 16'h0000, 1, "ws3_read_inject");
    xact(2, 0, 1, 16'h0FFF, 16'h4321, 0, "ws2_write");
    xact(2, 1, 0, 16'h0FFF, 16'h0000, 0, "ws2_read");
  endtask

  task automatic test_errors();
    for (int d = 0; d < 2; d++) begin
      xact(d, 0, 1, 16'h0000, 16'h5A5A, 0, "err_prewrite0");
      xact(d, 0, 1, 16'h0010, 16'h0101, 0, "err_prewrite10");
      xact(d, 1, 0, 16'h0000, 16'h0000, 0, "err_read0_before");
      xact(d, 0, 1, 16'h1000, 16'h7777, 0, "err_write_1000");
      xact(d, 1, 0, 16'hFFFF, 16'h0000, 0, "err_read_ffff");
      xact(d, 1, 1, 16'h0010, 16'hFFFF, 0, "err_rd_wr");
      xact(d, 1, 0, 16'h0000, 16'h0000, 0, "err_read0_after");
      xact(d, 1, 0, 16'h0010, 16'h0000, 0, "err_read10_after");
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int d;
      int kind;
      logic [15:0] a;
      d    = int'($urandom_range(0, 2));
      kind = int'($urandom_range(0, 7));
      if (kind == 0) begin
        a = 16'($urandom_range(4096, 65535));
        xact(d, $urandom_range(0, 1) == 1, 1'b1, a, 16'($urandom), 0, "rand_err_wr");
      end else if (kind == 1) begin
        a = 16'($urandom_range(4096, 65535));
        xact(d, 1'b1, $urandom_range(0, 1) == 1, a, 16'($urandom), 0, "rand_err_rd");
      end else if (kind <= 4 || wq[d].size() == 0) begin
        a = 16'($urandom_range(0, 4095));
        xact(d, 0, 1, a, 16'($urandom), 0, "rand_write");
      end else begin
        a = wq[d][$urandom_range(0, wq[d].size() - 1)];
        xact(d, 1, 0, a, 16'h0000, 0, "rand_read");
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      xact(0, 0, 1, 16'($urandom_range(0, 4095)), 16'($urandom), 0, "sat_write");
    end
    checks++;
    if (o_st[0] !== 8'd255) begin
      fails++;
      $display("FAIL sat_st_count: got %0d want 255", o_st[0]);
    end
    xact(0, 1, 0, wq[0][0], 16'h0000, 0, "sat_read_after");
  endtask

  task automatic test_reset_abort();
    bit stray;
    xact(2, 0, 1, 16'h0020, 16'h1111, 0, "abort_prewrite");
    t_addr[2] = 16'h0020; t_din[2] = 16'hAAAA; t_rd[2] = 1'b0; t_wr[2] = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("abort_in_reset");
    t_wr[2] = 1'b0;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_ready[2] !== 1'b0) stray = 1;
    end
    checks++;
    if (stray) begin
      fails++;
      $display("FAIL abort_no_ready: got ready pulse while in reset want none");
    end
    rst_n = 1'b1;
    xact(2, 1, 0, 16'h0020, 16'h0000, 0, "abort_read_after");
  endtask

  initial begin
    test_reset();
    test_basic_ws0();
    test_wait_states();
    test_errors();
    test_random();
    test_reset_abort();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
